// File: rtl/mips_pkg.sv
// Shared types for the decode-stage hazard controller.
// Holds register-index widths and the in-flight slot record.
package mips_pkg;

   localparam int REG_W = 5;
   localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

   typedef struct packed {
      logic             v;
      logic [REG_W-1:0] dest;
      logic             wb;
      logic             load;
   } slot_t;

   localparam slot_t SLOT_NONE = '0;

   function automatic slot_t mk_slot(
      input logic [REG_W-1:0] dest,
      input logic             wb,
      input logic             load
   );
      slot_t s;
      s.v    = 1'b1;
      s.dest = dest;
      s.wb   = wb;
      s.load = load;
      return s;
   endfunction

endpackage

// File: rtl/id_hazard_ctrl_if.sv
// Decode-side bundle: ID instruction info, branch resolution in,
// pipeline steering (pc/ifid/idex/ex controls, stall count) out.
interface id_hazard_ctrl_if #(
   parameter int CNT_W = 16
);
   import mips_pkg::*;

   logic             id_valid;
   logic [REG_W-1:0] id_rs;
   logic [REG_W-1:0] id_rt;
   logic             id_use_rs;
   logic             id_use_rt;
   logic [REG_W-1:0] id_dest;
   logic             id_wb_en;
   logic             id_is_load;
   logic             id_is_muldiv;
   logic             id_jump;
   logic             ex_branch_taken;

   logic             pc_write;
   logic             ifid_write;
   logic             ifid_flush;
   logic             idex_bubble;
   logic             ex_hold;
   logic [CNT_W-1:0] stall_cnt;

   modport master (
      output id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
      output id_dest, id_wb_en, id_is_load, id_is_muldiv,
      output id_jump, ex_branch_taken,
      input  pc_write, ifid_write, ifid_flush,
      input  idex_bubble, ex_hold, stall_cnt
   );

   modport slave (
      input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
      input  id_dest, id_wb_en, id_is_load, id_is_muldiv,
      input  id_jump, ex_branch_taken,
      output pc_write, ifid_write, ifid_flush,
      output idex_bubble, ex_hold, stall_cnt
   );

endinterface

// File: rtl/hz_slot_match.sv
// Compares one in-flight slot against the ID source registers.
// Ports: slot, rs/rt, use_rs/use_rt in; match, load_match out.
module hz_slot_match
   import mips_pkg::*;
(
   input  slot_t            slot,
   input  logic [REG_W-1:0] rs,
   input  logic [REG_W-1:0] rt,
   input  logic             use_rs,
   input  logic             use_rt,
   output logic             match,
   output logic             load_match
);

   logic live;

   // $0 is hardwired, so a write to it never creates a dependence.
   assign live = slot.v && slot.wb && (slot.dest != REG_ZERO);

   assign match = live &&
      ((use_rs && (slot.dest == rs)) ||
       (use_rt && (slot.dest == rt)));

   assign load_match = match && slot.load;

endmodule

// File: rtl/id_hazard_ctrl.sv
// Decode-stage sequencing: RAW stalls, mult/div hold, jump/branch flush.
// Ports: clk, rst_n (async, active-low), bus (id_hazard_ctrl_if.slave).
module id_hazard_ctrl
   import mips_pkg::*;
#(
   parameter int FORWARDING = 0,
   parameter int MULDIV_LAT = 4,
   parameter int CNT_W      = 16
) (
   input logic              clk,
   input logic              rst_n,
   id_hazard_ctrl_if.slave  bus
);

   localparam int MD_W = $clog2(MULDIV_LAT);
   localparam logic [MD_W-1:0] MD_INIT = MD_W'(MULDIV_LAT - 1);

   slot_t            ex_q;
   slot_t            mem_q;
   logic [MD_W-1:0]  md_cnt;
   logic [CNT_W-1:0] cnt_q;

   logic ex_m, ex_lm, mem_m, mem_lm;
   logic busy, raw_stall, issue;
   logic pc_w, ifid_w, flush, bubble, hold;

   hz_slot_match u_ex (
      .slot       (ex_q),
      .rs         (bus.id_rs),
      .rt         (bus.id_rt),
      .use_rs     (bus.id_use_rs),
      .use_rt     (bus.id_use_rt),
      .match      (ex_m),
      .load_match (ex_lm)
   );

   hz_slot_match u_mem (
      .slot       (mem_q),
      .rs         (bus.id_rs),
      .rt         (bus.id_rt),
      .use_rs     (bus.id_use_rs),
      .use_rt     (bus.id_use_rt),
      .match      (mem_m),
      .load_match (mem_lm)
   );

   assign busy = (md_cnt != '0);

   // MEM never records the load flag, so mem_lm is only a
   // structural term: with bypass, only a load in EX stalls.
   assign raw_stall = bus.id_valid &&
      ((FORWARDING != 0) ? (ex_lm | mem_lm) : (ex_m | mem_m));

   always_comb begin
      pc_w   = 1'b1;
      ifid_w = 1'b1;
      flush  = 1'b0;
      bubble = 1'b0;
      hold   = 1'b0;
      priority case (1'b1)
         !rst_n: begin
            pc_w   = 1'b0;
            ifid_w = 1'b0;
            bubble = 1'b1;
         end
         bus.ex_branch_taken: begin
            // Flush wins, but a running mult/div keeps EX.
            flush  = 1'b1;
            bubble = 1'b1;
            hold   = busy;
         end
         busy: begin
            pc_w   = 1'b0;
            ifid_w = 1'b0;
            hold   = 1'b1;
         end
         raw_stall: begin
            pc_w   = 1'b0;
            ifid_w = 1'b0;
            bubble = 1'b1;
         end
         (bus.id_jump && bus.id_valid): begin
            flush  = 1'b1;
         end
         default: ;
      endcase
   end

   assign issue = bus.id_valid && !bubble && !hold;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_q   <= SLOT_NONE;
         mem_q  <= SLOT_NONE;
         md_cnt <= '0;
         cnt_q  <= '0;
      end else begin
         if (hold) begin
            mem_q <= SLOT_NONE;
         end else begin
            mem_q      <= ex_q;
            mem_q.load <= 1'b0;
            ex_q       <= issue ?
               mk_slot(bus.id_dest, bus.id_wb_en, bus.id_is_load) :
               SLOT_NONE;
         end
         if (issue && bus.id_is_muldiv) begin
            md_cnt <= MD_INIT;
         end else if (busy) begin
            md_cnt <= md_cnt - 1'b1;
         end
         if (!pc_w && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

   assign bus.pc_write    = pc_w;
   assign bus.ifid_write  = ifid_w;
   assign bus.ifid_flush  = flush;
   assign bus.idex_bubble = bubble;
   assign bus.ex_hold     = hold;
   assign bus.stall_cnt   = cnt_q;

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Bench for id_hazard_ctrl: bypass (A, 3-bit counter) and
// no-bypass (B, 16-bit counter) instances share one input stream.
module tb_id_hazard_ctrl;

   localparam int LAT = 4;

   typedef struct packed {
      logic       v;
      logic [4:0] rs;
      logic [4:0] rt;
      logic       urs;
      logic       urt;
      logic [4:0] dest;
      logic       wb;
      logic       ld;
      logic       md;
      logic       jmp;
      logic       br;
   } in_t;

   typedef struct {
      int inst;
      int dest;
      bit wb;
      bit ld;
      bit md;
      int iss;
   } rec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   in_t  vin = '0;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc = 0;
   int   cnt_m [2];
   rec_t hist [$];

   always #5 clk = ~clk;

   id_hazard_ctrl_if #(.CNT_W(3))  bus_a ();
   id_hazard_ctrl_if #(.CNT_W(16)) bus_b ();

   id_hazard_ctrl #(
      .FORWARDING (1),
      .MULDIV_LAT (LAT),
      .CNT_W      (3)
   ) u_a (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_a)
   );

   id_hazard_ctrl #(
      .FORWARDING (0),
      .MULDIV_LAT (LAT),
      .CNT_W      (16)
   ) u_b (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_b)
   );

   assign bus_a.id_valid        = vin.v;
   assign bus_a.id_rs           = vin.rs;
   assign bus_a.id_rt           = vin.rt;
   assign bus_a.id_use_rs       = vin.urs;
   assign bus_a.id_use_rt       = vin.urt;
   assign bus_a.id_dest         = vin.dest;
   assign bus_a.id_wb_en        = vin.wb;
   assign bus_a.id_is_load      = vin.ld;
   assign bus_a.id_is_muldiv    = vin.md;
   assign bus_a.id_jump         = vin.jmp;
   assign bus_a.ex_branch_taken = vin.br;
   assign bus_b.id_valid        = vin.v;
   assign bus_b.id_rs           = vin.rs;
   assign bus_b.id_rt           = vin.rt;
   assign bus_b.id_use_rs       = vin.urs;
   assign bus_b.id_use_rt       = vin.urt;
   assign bus_b.id_dest         = vin.dest;
   assign bus_b.id_wb_en        = vin.wb;
   assign bus_b.id_is_load      = vin.ld;
   assign bus_b.id_is_muldiv    = vin.md;
   assign bus_b.id_jump         = vin.jmp;
   assign bus_b.ex_branch_taken = vin.br;

   task automatic chk(input string nm,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   // One cycle of ID-stage stimulus, applied just after the edge.
   task automatic put(input bit v, input int rs, input int rt,
                      input bit urs, input bit urt, input int dest,
                      input bit wb, input bit ld, input bit md,
                      input bit jmp, input bit br);
      @(posedge clk);
      #1;
      vin.v    = v;
      vin.rs   = 5'(rs);
      vin.rt   = 5'(rt);
      vin.urs  = urs;
      vin.urt  = urt;
      vin.dest = 5'(dest);
      vin.wb   = wb;
      vin.ld   = ld;
      vin.md   = md;
      vin.jmp  = jmp;
      vin.br   = br;
   endtask

   task automatic idle();
      put(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic rst_pulse();
      @(posedge clk);
      #1;
      vin   = '0;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   // Model: each issued instruction sits in EX from the cycle after
   // issue for 1 cycle (LAT cycles for mult/div), then in MEM for
   // exactly one cycle. Mult/div keeps the front end busy LAT-1 cycles.
   task automatic model_check(input int s);
      logic pc_o, ifw_o, fl_o, bub_o, hold_o;
      logic [15:0] cnt_o;
      string tg;
      bit busy, exm, exl, memm, raw, issue, hit;
      bit e_pc, e_ifw, e_fl, e_bub, e_hold;
      int first, last, maxc;
      rec_t r;
      busy = 0; exm = 0; exl = 0; memm = 0;
      if (s == 0) begin
         tg = "A"; maxc = 7;
         pc_o = bus_a.pc_write; ifw_o = bus_a.ifid_write;
         fl_o = bus_a.ifid_flush; bub_o = bus_a.idex_bubble;
         hold_o = bus_a.ex_hold; cnt_o = 16'(bus_a.stall_cnt);
      end else begin
         tg = "B"; maxc = 65535;
         pc_o = bus_b.pc_write; ifw_o = bus_b.ifid_write;
         fl_o = bus_b.ifid_flush; bub_o = bus_b.idex_bubble;
         hold_o = bus_b.ex_hold; cnt_o = bus_b.stall_cnt;
      end
      if (!rst_n) begin
         for (int i = hist.size() - 1; i >= 0; i--)
            if (hist[i].inst == s) hist.delete(i);
         cnt_m[s] = 0;
         e_pc = 0; e_ifw = 0; e_fl = 0; e_bub = 1; e_hold = 0;
      end else begin
         foreach (hist[i]) begin
            if (hist[i].inst == s) begin
               first = hist[i].iss + 1;
               last  = first + (hist[i].md ? LAT - 1 : 0);
               hit = hist[i].wb && hist[i].dest != 0 &&
                  ((vin.urs && hist[i].dest == int'(vin.rs)) ||
                   (vin.urt && hist[i].dest == int'(vin.rt)));
               if (hist[i].md && cyc >= first &&
                   cyc <= hist[i].iss + LAT - 1) busy = 1;
               if (cyc >= first && cyc <= last && hit) begin
                  exm = 1;
                  exl = hist[i].ld;
               end
               if (cyc == last + 1 && hit) memm = 1;
            end
         end
         raw = vin.v && ((s == 0) ? exl : (exm || memm));
         e_pc = 1; e_ifw = 1; e_fl = 0; e_bub = 0; e_hold = 0;
         if (vin.br) begin
            e_fl = 1; e_bub = 1; e_hold = busy;
         end else if (busy) begin
            e_pc = 0; e_ifw = 0; e_hold = 1;
         end else if (raw) begin
            e_pc = 0; e_ifw = 0; e_bub = 1;
         end else if (vin.jmp && vin.v) begin
            e_fl = 1;
         end
         issue = vin.v && !e_bub && !e_hold;
         if (issue) begin
            r.inst = s; r.dest = int'(vin.dest); r.wb = vin.wb;
            r.ld = vin.ld; r.md = vin.md; r.iss = cyc;
            hist.push_back(r);
         end
      end
      chk({tg, ".pc_write"}, pc_o, e_pc);
      chk({tg, ".ifid_write"}, ifw_o, e_ifw);
      chk({tg, ".ifid_flush"}, fl_o, e_fl);
      chk({tg, ".idex_bubble"}, bub_o, e_bub);
      chk({tg, ".ex_hold"}, hold_o, e_hold);
      chk({tg, ".stall_cnt"}, cnt_o, cnt_m[s]);
      if (rst_n && !e_pc && cnt_m[s] < maxc) cnt_m[s]++;
   endtask

   always @(negedge clk) begin
      model_check(0);
      model_check(1);
      cyc++;
   end

   initial begin
      cnt_m[0] = 0;
      cnt_m[1] = 0;
      #1 rst_n = 1'b0;
      @(negedge clk);
      chk("rst_pc_A", bus_a.pc_write, 0);
      chk("rst_bub_B", bus_b.idex_bubble, 1);
      chk("rst_cnt_B", bus_b.stall_cnt, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // load-use: lw $8 ; add $9,$8,$1
      put(1, 2, 0, 1, 0, 8, 1, 1, 0, 0, 0);
      put(1, 8, 1, 1, 1, 9, 1, 0, 0, 0, 0);
      @(negedge clk);
      chk("lu_pc_A", bus_a.pc_write, 0);
      chk("lu_bub_A", bus_a.idex_bubble, 1);
      put(1, 8, 1, 1, 1, 9, 1, 0, 0, 0, 0);
      @(negedge clk);
      chk("lu_go_A", bus_a.pc_write, 1);
      chk("lu_mem_B", bus_b.pc_write, 0);
      idle();
      @(negedge clk);
      chk("lu_cnt_A", bus_a.stall_cnt, 1);

      // no bypass: addi $5 ; sub $6,$5,$5
      rst_pulse();
      put(1, 1, 0, 1, 0, 5, 1, 0, 0, 0, 0);
      put(1, 5, 5, 1, 1, 6, 1, 0, 0, 0, 0);
      @(negedge clk);
      chk("nf_ex_B", bus_b.pc_write, 0);
      put(1, 5, 5, 1, 1, 6, 1, 0, 0, 0, 0);
      @(negedge clk);
      chk("nf_mem_B", bus_b.pc_write, 0);
      put(1, 5, 5, 1, 1, 6, 1, 0, 0, 0, 0);
      @(negedge clk);
      chk("nf_go_B", bus_b.idex_bubble, 0);
      idle();
      @(negedge clk);
      chk("nf_cnt_B", bus_b.stall_cnt, 2);

      // $0 destination never matches
      rst_pulse();
      put(1, 1, 0, 1, 0, 0, 1, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         put(1, 0, 0, 1, 1, 3, 1, 0, 0, 0, 0);
         @(negedge clk);
         chk("z0_pc_B", bus_b.pc_write, 1);
      end

      // mult/div hold: addi $7 ; mult ; addu reading $7
      rst_pulse();
      put(1, 1, 0, 1, 0, 7, 1, 0, 0, 0, 0);
      put(1, 2, 3, 1, 1, 0, 0, 0, 1, 0, 0);
      for (int i = 0; i < LAT - 1; i++) begin
         put(1, 7, 7, 1, 1, 10, 1, 0, 0, 0, 0);
         @(negedge clk);
         chk("md_hold_A", bus_a.ex_hold, 1);
         chk("md_pc_B", bus_b.pc_write, 0);
      end
      put(1, 7, 7, 1, 1, 10, 1, 0, 0, 0, 0);
      @(negedge clk);
      chk("md_end_A", bus_a.ex_hold, 0);
      chk("md_memclr_B", bus_b.pc_write, 1);
      idle();

      // branch beats a load-use stall
      rst_pulse();
      put(1, 2, 0, 1, 0, 8, 1, 1, 0, 0, 0);
      put(1, 8, 1, 1, 1, 9, 1, 0, 0, 0, 1);
      @(negedge clk);
      chk("br_fl_A", bus_a.ifid_flush, 1);
      chk("br_bub_A", bus_a.idex_bubble, 1);
      chk("br_pc_A", bus_a.pc_write, 1);
      idle();

      // jump waits for the hazard, then flushes once
      rst_pulse();
      put(1, 2, 0, 1, 0, 8, 1, 1, 0, 0, 0);
      put(1, 8, 0, 1, 0, 0, 0, 0, 0, 1, 0);
      @(negedge clk);
      chk("jmp_wait_A", bus_a.ifid_flush, 0);
      put(1, 8, 0, 1, 0, 0, 0, 0, 0, 1, 0);
      @(negedge clk);
      chk("jmp_fl_A", bus_a.ifid_flush, 1);
      idle();

      // reset asserted in the middle of a stall
      put(1, 2, 0, 1, 0, 8, 1, 1, 0, 0, 0);
      put(1, 8, 1, 1, 1, 9, 1, 0, 0, 0, 0);
      @(negedge clk);
      chk("mr_stall_A", bus_a.pc_write, 0);
      put(1, 8, 1, 1, 1, 9, 1, 0, 0, 0, 0);
      rst_n = 1'b0;
      @(negedge clk);
      chk("mr_pc_A", bus_a.pc_write, 0);
      chk("mr_bub_A", bus_a.idex_bubble, 1);
      chk("mr_cnt_A", bus_a.stall_cnt, 0);
      put(1, 8, 1, 1, 1, 9, 1, 0, 0, 0, 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("mr_clr_B", bus_b.pc_write, 1);

      // counter saturation: three mult/div ops, 9 stall cycles
      rst_pulse();
      for (int k = 0; k < 3; k++) begin
         put(1, 2, 3, 1, 1, 0, 0, 0, 1, 0, 0);
         repeat (LAT - 1) idle();
      end
      idle();
      @(negedge clk);
      chk("sat_cnt_A", bus_a.stall_cnt, 7);
      chk("sat_cnt_B", bus_b.stall_cnt, 9);

      @(posedge clk);
      @(negedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
